dcache_write_buffer: RTL and testbench
======================================

# dcache_write_buffer

Line-granular write-back buffer between the data cache's memory-side (DFP) port and the dcache port of the cacheline adapter. Dirty-line evictions are absorbed in a small FIFO and acknowledged in two cycles, so the subsequent refill read reaches memory before the eviction drains. Cache reads that hit a buffered line are served from the buffer; all other reads pass through to the adapter. Buffered writes drain to the adapter whenever no cache request is pending.

## Interface
- DEPTH, 2, number of 256-bit line entries; must be 2 or more, power of two.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- c_addr  in  32  line address from dcache; bits [4:0] ignored.
- c_read  in  1  read request, held until c_resp.
- c_write  in  1  write (eviction) request, held until c_resp; never high together with c_read.
- c_wdata  in  256  eviction line data.
- c_rdata  out  256  read line data, valid while c_resp=1.
- c_resp  out  1  one-cycle completion pulse for c_read or c_write.
- m_addr  out  32  line address to adapter; bits [4:0] are always 0.
- m_read  out  1  read to adapter, held until m_resp.
- m_write  out  1  write to adapter, held until m_resp.
- m_wdata  out  256  write line data.
- m_rdata  in  256  adapter read data, valid with m_resp.
- m_resp  in  1  adapter completion pulse.
- wb_count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: circular FIFO of DEPTH entries {valid, tag = addr[31:5], data[255:0]}, with head and tail pointers and a count.
- FSM states: IDLE, RESP, MEM_READ, DRAIN.
- IDLE, in priority order:
  - c_read and the tag matches a valid entry: latch that entry's data into the response register, go to RESP. If several entries match, the youngest wins.
  - c_read with no match: latch the address, go to MEM_READ.
  - c_write and the tag matches a valid entry: overwrite that entry's data (coalesce, count unchanged), go to RESP.
  - c_write, no match, not full: write the tail entry, advance tail, count+1, go to RESP.
  - c_write, no match, full: go to DRAIN; the write stays pending upstream.
  - No cache request and count>0: go to DRAIN.
- MEM_READ: m_read=1, m_addr = {latched addr[31:5], 5'b0}. On m_resp, capture m_rdata and go to RESP.
- DRAIN: m_write=1, m_addr = {head tag, 5'b0}, m_wdata = head data. On m_resp, invalidate head, advance head, count-1, go to IDLE.
  - A drain is never preempted once started.
  - A cache read arriving mid-drain waits for the drain to finish.
- RESP: c_resp=1, c_rdata = response register. Always returns to IDLE. c_read and c_write are ignored in this cycle because the cache drops its request on c_resp.
- Reads never allocate entries. Memory never holds data newer than a buffered entry, so a read miss may safely go to memory.
- Pointers wrap modulo DEPTH. Count saturates at DEPTH by construction, since there is no allocation when full.

## Timing
- Reset (rst=0): state=IDLE, all entries invalid, head=tail=0, wb_count=0, c_resp=0, c_rdata=0, m_read=0, m_write=0, m_addr=0, m_wdata=0.
  - Reset takes effect immediately, including mid-drain or mid-read.
  - m_read and m_write drop without waiting for the clock. Buffer contents are discarded.
- Buffered write or read hit: request seen in cycle T, c_resp=1 in cycle T+1.
- Read miss: request in T, m_read=1 from T+1 until the m_resp cycle R, c_resp=1 in R+1.
- Drain: m_write=1 from entry into DRAIN through the m_resp cycle. wb_count decrements in the cycle after m_resp.
- Write while full: c_resp arrives 2 cycles after the drain's m_resp (IDLE accept, then RESP).
- m_read/m_write and c_resp are decoded from the state register. Data and address outputs come from registers. There are no combinational paths from inputs to outputs.
- m_read and m_write are never both 1. c_resp is never high for two consecutive cycles.

## Test plan
- Reset, then c_write addr 0x1000 data D0 -> c_resp one cycle later. wb_count=1, then drain begins: m_write=1, m_addr=0x1000, m_wdata=D0; after m_resp, wb_count=0.
- Hold m_resp low and write 0x1000 then 0x2000 -> wb_count=2. A third write to 0x3000 -> no c_resp; m_write to 0x1000 starts. Pulse m_resp -> 0x3000 accepted, c_resp 2 cycles later, wb_count=2.
- Buffer holds 0x2000=D1, c_read 0x2000 -> c_resp next cycle with c_rdata=D1, m_read stays 0.
- Buffer holds 0x2000=D1, c_write 0x2000 with D2 -> wb_count unchanged. A read of 0x2000 returns D2, and the drain later writes D2 once.
- c_read 0x4000 (miss) with buffer non-empty -> m_read precedes any m_write. m_rdata=R on m_resp -> c_resp=1, c_rdata=R one cycle later.
- Deassert rst mid-drain -> m_write=0 immediately, wb_count=0. After release, a read of the previously buffered address goes to memory via m_read.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// Line-granular write-back buffer between the dcache memory-side port and the
// cacheline adapter: absorbs evictions in a small FIFO, serves read hits, drains when idle.
module dcache_write_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  c_addr,
  input  logic                         c_read,
  input  logic                         c_write,
  input  logic [255:0]                 c_wdata,
  output logic [255:0]                 c_rdata,
  output logic                         c_resp,
  output logic [31:0]                  m_addr,
  output logic                         m_read,
  output logic                         m_write,
  output logic [255:0]                 m_wdata,
  input  logic [255:0]                 m_rdata,
  input  logic                         m_resp,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RESP     = 2'd1;
  localparam logic [1:0] MEM_READ = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [26:0]      tag_q  [DEPTH];
  logic [255:0]     data_q [DEPTH];
  logic [255:0]     rdata_q, rdata_d;
  logic [255:0]     mwdata_q, mwdata_d;
  logic [31:0]      maddr_q, maddr_d;

  logic             hit;
  logic [PW-1:0]    hitIdx;
  logic [PW-1:0]    scanIdx;
  logic             wrEn;
  logic [PW-1:0]    wrIdx;
  logic             full;
  logic             startDrain;
  logic             unusedAddrLsb;

  assign unusedAddrLsb = ^c_addr[4:0];
  assign full          = (count_q == CW'(DEPTH));

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    hit     = 1'b0;
    hitIdx  = '0;
    scanIdx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head_q + PW'(k);
      if (valid_q[scanIdx] && (tag_q[scanIdx] == c_addr[31:5])) begin
        hit    = 1'b1;
        hitIdx = scanIdx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    rdata_d    = rdata_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    wrEn       = 1'b0;
    wrIdx      = tail_q;
    startDrain = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_read) begin
          if (hit) begin
            rdata_d = data_q[hitIdx];
            state_d = RESP;
          end else begin
            maddr_d = {c_addr[31:5], 5'b0};
            state_d = MEM_READ;
          end
        end else if (c_write) begin
          if (hit) begin
            wrEn    = 1'b1;
            wrIdx   = hitIdx;
            state_d = RESP;
          end else if (!full) begin
            wrEn            = 1'b1;
            wrIdx           = tail_q;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
            count_d         = count_q + CW'(1);
            state_d         = RESP;
          end else begin
            // The write stays held upstream and is accepted once a slot frees up.
            startDrain = 1'b1;
          end
        end else if (count_q != '0) begin
          startDrain = 1'b1;
        end
      end
      MEM_READ: begin
        if (m_resp) begin
          rdata_d = m_rdata;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (m_resp) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + PW'(1);
          count_d         = count_q - CW'(1);
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (startDrain) begin
      state_d  = DRAIN;
      maddr_d  = {tag_q[head_q], 5'b0};
      mwdata_d = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Entry payloads need no reset; the valid bits alone define buffer contents.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tag_q[wrIdx]  <= c_addr[31:5];
      data_q[wrIdx] <= c_wdata;
    end
  end

  assign c_resp   = (state_q == RESP);
  assign m_read   = (state_q == MEM_READ);
  assign m_write  = (state_q == DRAIN);
  assign c_rdata  = rdata_q;
  assign m_addr   = maddr_q;
  assign m_wdata  = mwdata_q;
  assign wb_count = count_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: a transaction-level buffer/memory model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_dcache_write_buffer;

  localparam int DEPTH = 2;

  localparam logic [255:0] D0 = {8{32'hD0D0_0000}};
  localparam logic [255:0] D1 = {8{32'hD1D1_1111}};
  localparam logic [255:0] D2 = {8{32'hD2D2_2222}};
  localparam logic [255:0] D3 = {8{32'hD3D3_3333}};
  localparam logic [255:0] D5 = {8{32'hD5D5_5555}};

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  c_addr;
  logic         c_read;
  logic         c_write;
  logic [255:0] c_wdata;
  logic [255:0] c_rdata;
  logic         c_resp;
  logic [31:0]  m_addr;
  logic         m_read;
  logic         m_write;
  logic [255:0] m_wdata;
  logic [255:0] m_rdata;
  logic         m_resp;
  logic [1:0]   wb_count;

  dcache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c_addr(c_addr), .c_read(c_read), .c_write(c_write), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_resp(c_resp),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } entry_t;

  entry_t       modelQ[$];
  logic [255:0] memArr [logic [31:0]];
  int           writeCnt [logic [31:0]];
  int           checks = 0;
  int           passCount = 0;
  bit           autoResp = 1'b0;
  int           respDelay = 0;
  int           manualReq = 0;
  int           manualDone = 0;
  bit           pendingPop = 1'b0;
  bit           prevResp = 1'b0;

  function automatic logic [255:0] memInit(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [255:0] memValue(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return memInit(a);
  endfunction

  function automatic int getWriteCnt(input logic [31:0] a);
    if (writeCnt.exists(a)) return writeCnt[a];
    return 0;
  endfunction

  function automatic int findYoungest(input logic [31:0] a);
    for (int i = modelQ.size() - 1; i >= 0; i--)
      if (modelQ[i].addr == a) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [255:0] data, output int lat, output int sawW,
                               output int sawR, output logic [255:0] rdata);
    bit done;
    c_write = wr;
    c_read  = rd;
    c_addr  = addr;
    c_wdata = data;
    lat = 0; sawW = 0; sawR = 0; rdata = '0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (m_write) sawW++;
      if (m_read) sawR++;
      if (c_resp) begin
        rdata = c_rdata;
        done  = 1'b1;
      end else if (lat >= 60) begin
        checks++;
        $display("[TB] FAIL req_timeout: no c_resp after %0d cycles for addr %h", lat, addr);
        done = 1'b1;
      end
    end
    #1;
    c_write = 1'b0;
    c_read  = 1'b0;
  endtask

  // Memory-side responder: the only driver of m_resp/m_rdata.
  initial begin
    int busy;
    busy = 0;
    m_resp = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      m_resp = 1'b0;
      if (!rst || !(m_read || m_write)) begin
        busy = 0;
      end else if ((manualReq != manualDone) || (autoResp && busy >= respDelay)) begin
        m_resp  = 1'b1;
        m_rdata = m_read ? memValue(m_addr) : '0;
        busy = 0;
        manualDone = manualReq;
      end else begin
        busy++;
      end
    end
  end

  // Every-cycle comparison against the buffer/memory model.
  initial begin
    logic [31:0] cmpAddr;
    int          cmpIdx;
    forever begin
      @(negedge clk);
      if (!rst) begin
        modelQ.delete();
        pendingPop = 1'b0;
        prevResp   = 1'b0;
        checkOutput("rst_c_resp", c_resp, 0);
        checkOutput("rst_c_rdata", c_rdata, 0);
        checkOutput("rst_m_read", m_read, 0);
        checkOutput("rst_m_write", m_write, 0);
        checkOutput("rst_m_addr", m_addr, 0);
        checkOutput("rst_m_wdata", m_wdata, 0);
        checkOutput("rst_wb_count", wb_count, 0);
      end else begin
        if (pendingPop) begin
          if (modelQ.size() != 0) modelQ.delete(0);
          pendingPop = 1'b0;
        end
        if (c_resp) begin
          checkOutput("c_resp_single", prevResp, 0);
          checkOutput("c_resp_has_req", c_read | c_write, 1);
          cmpAddr = c_addr & ~32'h1f;
          cmpIdx  = findYoungest(cmpAddr);
          if (c_write) begin
            if (cmpIdx >= 0) modelQ[cmpIdx].data = c_wdata;
            else modelQ.push_back('{cmpAddr, c_wdata});
          end else if (c_read) begin
            checkOutput("c_rdata", c_rdata, (cmpIdx >= 0) ? modelQ[cmpIdx].data : memValue(cmpAddr));
          end
        end
        checkOutput("wb_count", wb_count, modelQ.size());
        checkOutput("m_read_write_excl", m_read & m_write, 0);
        if (m_write) begin
          checkOutput("drain_nonempty", modelQ.size() != 0, 1);
          if (modelQ.size() != 0) begin
            checkOutput("drain_m_addr", m_addr, modelQ[0].addr);
            checkOutput("drain_m_wdata", m_wdata, modelQ[0].data);
            if (m_resp) begin
              memArr[m_addr] = m_wdata;
              writeCnt[m_addr] = getWriteCnt(m_addr) + 1;
              pendingPop = 1'b1;
            end
          end
        end
        if (m_read) begin
          checkOutput("read_m_addr", m_addr, c_addr & ~32'h1f);
          checkOutput("read_not_buffered", findYoungest(m_addr) < 0, 1);
        end
        prevResp = c_resp;
      end
    end
  end

  initial begin
    int lat, sw, sr;
    logic [255:0] rd;
    rst = 1'b0;
    c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_wb_count", wb_count, 0);
    #1 rst = 1'b1;

    // Single buffered write, then an idle drain held until a manual m_resp.
    applyStimulus(1, 0, 32'h1000, D0, lat, sw, sr, rd);
    checkOutput("w1_lat", lat, 1);
    checkOutput("w1_count", wb_count, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drain1_m_write", m_write, 1);
    checkOutput("drain1_m_addr", m_addr, 32'h1000);
    checkOutput("drain1_m_wdata", m_wdata, D0);
    manualReq++;
    @(negedge clk);
    @(negedge clk);
    checkOutput("drain1_count", wb_count, 0);
    checkOutput("drain1_m_write_low", m_write, 0);
    #1;

    // Fill the buffer back-to-back, then a third write must wait for a drain.
    applyStimulus(1, 0, 32'h1000, D0, lat, sw, sr, rd);
    checkOutput("fill1_lat", lat, 1);
    applyStimulus(1, 0, 32'h2000, D1, lat, sw, sr, rd);
    checkOutput("fill2_lat", lat, 2);
    checkOutput("fill_count", wb_count, 2);
    fork
      applyStimulus(1, 0, 32'h3000, D3, lat, sw, sr, rd);
      begin
        @(negedge clk);
        repeat (2) begin
          @(negedge clk);
          checkOutput("full_no_resp", c_resp, 0);
          checkOutput("full_drain_write", m_write, 1);
          checkOutput("full_drain_addr", m_addr, 32'h1000);
        end
        manualReq++;
      end
    join
    checkOutput("full_lat", lat, 6);
    checkOutput("full_count", wb_count, 2);

    // Read hit, coalescing write, read hit of the new data.
    applyStimulus(0, 1, 32'h2000, '0, lat, sw, sr, rd);
    checkOutput("hit_lat", lat, 2);
    checkOutput("hit_rdata", rd, D1);
    checkOutput("hit_no_m_read", sr, 0);
    applyStimulus(1, 0, 32'h2004, D2, lat, sw, sr, rd);
    checkOutput("coalesce_lat", lat, 2);
    checkOutput("coalesce_count", wb_count, 2);
    applyStimulus(0, 1, 32'h2000, '0, lat, sw, sr, rd);
    checkOutput("hit2_rdata", rd, D2);

    // Read miss with a non-empty buffer goes to memory before any drain.
    autoResp  = 1'b1;
    respDelay = 2;
    applyStimulus(0, 1, 32'h4000, '0, lat, sw, sr, rd);
    checkOutput("miss_lat", lat, 5);
    checkOutput("miss_no_m_write", sw, 0);
    checkOutput("miss_m_read_cycles", sr, 3);
    checkOutput("miss_rdata", rd, memInit(32'h4000));

    for (int i = 0; i < 100 && wb_count != 0; i++) @(negedge clk);
    checkOutput("drain_all_count", wb_count, 0);
    checkOutput("mem_2000", memValue(32'h2000), D2);
    checkOutput("writes_2000", getWriteCnt(32'h2000), 1);
    checkOutput("mem_3000", memValue(32'h3000), D3);

    // Asynchronous reset in the middle of a drain discards the buffered line.
    autoResp = 1'b0;
    #1;
    applyStimulus(1, 0, 32'h5000, D5, lat, sw, sr, rd);
    checkOutput("w5_lat", lat, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drain5_m_write", m_write, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_m_write", m_write, 0);
    checkOutput("async_wb_count", wb_count, 0);
    checkOutput("async_m_read", m_read, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    autoResp  = 1'b1;
    respDelay = 0;
    applyStimulus(0, 1, 32'h5000, '0, lat, sw, sr, rd);
    checkOutput("post_rst_lat", lat, 2);
    checkOutput("post_rst_m_read", sr, 1);
    checkOutput("post_rst_rdata", rd, memInit(32'h5000));
    checkOutput("post_rst_no_write", getWriteCnt(32'h5000), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checks);
    $finish;
  end

endmodule
